// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object path: object-list geometry and
// the object DMA state encoding.
package jtpopeye_pkg;

  localparam int OBJ_AW  = 10;
  localparam int OBJ_LEN = 768;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    REL
  } objdma_st_t;

endpackage

// File: rtl/jtpopeye_objdma.sv
// Once-per-frame copy of the sprite attribute table from CPU RAM into object
// RAM, taking the Z80 bus with busrq/busak and running only inside VB.
module jtpopeye_objdma
  import jtpopeye_pkg::*;
#(
  parameter int AW  = OBJ_AW,
  parameter int LEN = OBJ_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          VB,
  input  logic          dma_en,
  input  logic          busak,
  output logic          busrq,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_din,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          obj_we,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  // One spare counter bit so LEN = 2^AW reaches its last byte without wrapping
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  objdma_st_t    st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          VBl;
  logic          vb_edge;
  logic          we_q;
  logic          done_q;

  assign vb_edge = VB & ~VBl;
  assign cnt_nxt = cnt + CW'(1);

  // Strobes are held for a whole cen period but only count on the cen clock
  assign obj_we = we_q & pxl_cen;
  assign done   = done_q & pxl_cen;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= '0;
      VBl      <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      busrq    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      src_addr <= '0;
      obj_addr <= '0;
      obj_dout <= '0;
    end else if (pxl_cen) begin
      VBl    <= VB;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (vb_edge && dma_en) begin
            cnt     <= '0;
            overrun <= 1'b0;
            busrq   <= 1'b1;
            busy    <= 1'b1;
            st      <= REQ;
          end
        end
        REQ: begin
          if (!VB) begin
            overrun <= 1'b1;
            st      <= REL;
          end else if (busak) begin
            src_addr <= cnt[AW-1:0];
            st       <= RD;
          end
        end
        RD: begin
          // src_din for src_addr becomes valid at this cen
          st <= WR;
        end
        WR: begin
          obj_addr <= cnt[AW-1:0];
          obj_dout <= src_din;
          we_q     <= 1'b1;
          if (cnt == LAST) begin
            done_q <= 1'b1;
            st     <= REL;
          end else if (!VB) begin
            overrun <= 1'b1;
            st      <= REL;
          end else begin
            cnt      <= cnt_nxt;
            src_addr <= cnt_nxt[AW-1:0];
            st       <= busak ? RD : REQ;
          end
        end
        REL: begin
          busrq <= 1'b0;
          busy  <= 1'b0;
          st    <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Frame-level bench for jtpopeye_objdma: three instances (LEN=8, default
// 768-byte table, AW=4/LEN=16), each with its own VB, dma_en and busak.
module tb_jtpopeye_objdma;

  logic       clk = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       rst;
  logic [2:0] vb, en, ak;
  logic [2:0] busrq, busy, we, done, ovr;
  logic [9:0] sa0, oa0, sa1, oa1;
  logic [3:0] sa2, oa2;
  logic [7:0] sd0, sd1, sd2, od0, od1, od2;

  int checks = 0;
  int errors = 0;
  int hits [3][1024];
  int wr_total [3];
  int done_total [3];
  int exp_next [3];

  typedef struct {
    int idx;
    bit en;
    int lat;
    int steal_at;
    int steal_len;
    int vb_len;
    int exp_wr;
    int exp_done;
    bit exp_ovr;
    bit exp_req;
  } frame_t;

  always #5 clk = ~clk;
  always @(posedge clk) pxl_cen <= ~pxl_cen;

  // Source RAM models: data for an address is valid one cen after it
  always @(posedge clk) if (pxl_cen) sd0 <= 8'hA0 + sa0[7:0];
  always @(posedge clk) if (pxl_cen) sd1 <= 8'hA0 + sa1[7:0];
  always @(posedge clk) if (pxl_cen) sd2 <= 8'hA0 + {4'd0, sa2};

  jtpopeye_objdma #(.AW(10), .LEN(8)) u_d8 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(vb[0]), .dma_en(en[0]), .busak(ak[0]),
    .busrq(busrq[0]), .src_addr(sa0), .src_din(sd0), .obj_addr(oa0), .obj_dout(od0),
    .obj_we(we[0]), .busy(busy[0]), .done(done[0]), .overrun(ovr[0])
  );

  jtpopeye_objdma u_d768 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(vb[1]), .dma_en(en[1]), .busak(ak[1]),
    .busrq(busrq[1]), .src_addr(sa1), .src_din(sd1), .obj_addr(oa1), .obj_dout(od1),
    .obj_we(we[1]), .busy(busy[1]), .done(done[1]), .overrun(ovr[1])
  );

  jtpopeye_objdma #(.AW(4), .LEN(16)) u_d16 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(vb[2]), .dma_en(en[2]), .busak(ak[2]),
    .busrq(busrq[2]), .src_addr(sa2), .src_din(sd2), .obj_addr(oa2), .obj_dout(od2),
    .obj_we(we[2]), .busy(busy[2]), .done(done[2]), .overrun(ovr[2])
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int oaddr(input int i);
    case (i)
      0:       return int'(oa0);
      1:       return int'(oa1);
      default: return int'(oa2);
    endcase
  endfunction

  function automatic int odat(input int i);
    case (i)
      0:       return int'(od0);
      1:       return int'(od1);
      default: return int'(od2);
    endcase
  endfunction

  function automatic int saddr(input int i);
    case (i)
      0:       return int'(sa0);
      1:       return int'(sa1);
      default: return int'(sa2);
    endcase
  endfunction

  function automatic int len_of(input int i);
    case (i)
      0:       return 8;
      1:       return 768;
      default: return 16;
    endcase
  endfunction

  // Write monitor: in-order addresses, source data, done on the last byte
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pxl_cen && we[i]) begin
        check("wr_addr", oaddr(i), exp_next[i]);
        check("wr_data", odat(i), (oaddr(i) + 32'hA0) & 255);
        hits[i][oaddr(i)]++;
        wr_total[i]++;
        exp_next[i] = oaddr(i) + 1;
      end
      if (pxl_cen && done[i]) begin
        check("done_addr", oaddr(i), len_of(i) - 1);
        done_total[i]++;
      end
      if (!pxl_cen) check("strobe_len", {30'd0, we[i], done[i]}, 0);
    end
  end

  task automatic step();
    @(negedge clk);
    while (!pxl_cen) @(negedge clk);
  endtask

  task automatic clear_mon(input int i);
    for (int a = 0; a < 1024; a++) hits[i][a] = 0;
    wr_total[i]   = 0;
    done_total[i] = 0;
    exp_next[i]   = 0;
  endtask

  task automatic run_frame(input string tag, input frame_t f);
    int  i;
    int  acnt;
    int  steal_left;
    int  bad;
    bit  stolen;
    bit  req_seen;
    i          = f.idx;
    acnt       = 0;
    steal_left = 0;
    stolen     = 1'b0;
    req_seen   = 1'b0;
    clear_mon(i);
    en[i] = f.en;
    step();
    vb[i] = 1'b1;
    for (int t = 1; t <= f.vb_len + 12; t++) begin
      step();
      if (t == f.vb_len) vb[i] = 1'b0;
      if (busrq[i]) begin
        req_seen = 1'b1;
        acnt++;
        // Take the bus back while the engine presents address steal_at
        if (!stolen && f.steal_at >= 0 && ak[i] && saddr(i) == f.steal_at) begin
          stolen     = 1'b1;
          steal_left = f.steal_len;
        end
        if (steal_left > 0) begin
          ak[i] = 1'b0;
          steal_left--;
        end else begin
          ak[i] = (acnt > f.lat);
        end
      end else begin
        ak[i] = 1'b0;
        acnt  = 0;
      end
    end
    en[i] = 1'b0;
    bad = 0;
    for (int a = 0; a < f.exp_wr; a++) if (hits[i][a] != 1) bad++;
    check({tag, "_writes"}, wr_total[i], f.exp_wr);
    check({tag, "_once"}, bad, 0);
    check({tag, "_done"}, done_total[i], f.exp_done);
    check({tag, "_overrun"}, int'(ovr[i]), int'(f.exp_ovr));
    check({tag, "_req_seen"}, int'(req_seen), int'(f.exp_req));
    check({tag, "_busrq_end"}, int'(busrq[i]), 0);
    check({tag, "_busy_end"}, int'(busy[i]), 0);
  endtask

  task automatic check_reset_vals(input string tag, input int i);
    check({tag, "_busrq"}, int'(busrq[i]), 0);
    check({tag, "_busy"}, int'(busy[i]), 0);
    check({tag, "_obj_we"}, int'(we[i]), 0);
    check({tag, "_done"}, int'(done[i]), 0);
    check({tag, "_overrun"}, int'(ovr[i]), 0);
    check({tag, "_src_addr"}, saddr(i), 0);
    check({tag, "_obj_addr"}, oaddr(i), 0);
    check({tag, "_obj_dout"}, odat(i), 0);
  endtask

  frame_t tbl [9];
  frame_t post;
  int     n;
  bit     found;

  initial begin
    //           idx en lat steal len vb   wr  done ovr req
    tbl[0] = '{0, 1, 3, -1, 0, 60,  8,   1, 0, 1};  // nominal
    tbl[1] = '{0, 0, 3, -1, 0, 60,  0,   0, 0, 0};  // disabled
    tbl[2] = '{0, 1, 1,  3, 5, 60,  8,   1, 0, 1};  // bus stolen after byte 3
    tbl[3] = '{0, 1, 2, -1, 0, 8,   3,   0, 1, 1};  // VB ends during byte 2
    tbl[4] = '{0, 0, 2, -1, 0, 60,  0,   0, 1, 0};  // disabled keeps overrun
    tbl[5] = '{0, 1, 2, -1, 0, 60,  8,   1, 0, 1};  // armed edge clears overrun
    tbl[6] = '{2, 1, 2, -1, 0, 60,  16,  1, 0, 1};  // AW=4, LEN=16, no wrap
    tbl[7] = '{1, 1, 2, -1, 0, 204, 101, 0, 1, 1};  // VB ends during byte 100
    tbl[8] = '{1, 1, 1, -1, 0, 20,  9,   0, 1, 1};  // VB ends during byte 8
    post   = '{1, 1, 1, -1, 0, 20,  9,   0, 1, 1};

    rst = 1'b1;
    vb  = '0;
    en  = '0;
    ak  = '0;
    for (int i = 0; i < 3; i++) clear_mon(i);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_vals($sformatf("reset%0d", i), i);
    rst = 1'b0;
    repeat (3) step();

    // Latencies on the LEN=8 instance with busak returned immediately
    clear_mon(0);
    en[0] = 1'b1;
    step();
    vb[0] = 1'b1;
    step();
    check("lat_busrq", int'(busrq[0]), 1);
    ak[0] = 1'b1;
    n = 0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      step();
      n++;
      if (we[0]) found = 1'b1;
    end
    check("lat_first_we", n, 3);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (done[0]) found = 1'b1;
      else step();
    end
    check("lat_done_seen", int'(found), 1);
    check("lat_busrq_hold", int'(busrq[0]), 1);
    step();
    check("lat_busrq_fall", int'(busrq[0]), 0);
    check("lat_busy_fall", int'(busy[0]), 0);
    check("lat_writes", wr_total[0], 8);
    vb[0] = 1'b0;
    en[0] = 1'b0;
    ak[0] = 1'b0;
    repeat (4) step();

    for (int k = 0; k < 9; k++) run_frame($sformatf("f%0d", k), tbl[k]);

    // Reset in the middle of a 768-byte copy, on a non-cen clock edge
    clear_mon(1);
    en[1] = 1'b1;
    step();
    vb[1] = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      step();
      ak[1] = busrq[1];
      if (we[1] && oa1 == 10'd20) found = 1'b1;
    end
    check("rst_reach_byte20", int'(found), 1);
    @(negedge clk);
    rst   = 1'b1;
    vb[1] = 1'b0;
    en[1] = 1'b0;
    ak[1] = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid", 1);
    rst = 1'b0;
    repeat (3) step();
    run_frame("post_rst", post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
